// File: rtl/move_scheduler.sv
// move_scheduler: owns the active brick and time-shares one combinational collision
// checker among spawn/drop/gravity/move/rotate requesters. Optional: WALL_KICK_EN.
`ifndef POS_LEN
`define POS_LEN 10
`endif
`ifndef DIR_LEN
`define DIR_LEN 2
`endif
`ifndef BRICK_LEN
`define BRICK_LEN 3
`endif
`ifndef BRICK_I
`define BRICK_I 3'd1
`endif
`ifndef MAKE_POS
`define MAKE_POS(x, y) {5'(x), 5'(y)}
`endif

module move_scheduler #(
  parameter int SPAWN_X  = 6,
  parameter int SPAWN_Y  = 18,
  parameter int DROP_MAX = 20
) (
  input  logic                  main_clk,
  input  logic                  rst_1plus,
  input  logic                  req_left,
  input  logic                  req_right,
  input  logic                  req_down,
  input  logic                  req_rot,
  input  logic                  req_grav,
  input  logic                  req_drop,
  input  logic                  spawn_req,
  input  logic [`BRICK_LEN-1:0] spawn_type,
  input  logic                  is_collided,
  input  logic                  lock_ack,
  output logic [`POS_LEN-1:0]   try_pos,
  output logic [`DIR_LEN-1:0]   try_dir,
  output logic [`BRICK_LEN-1:0] try_brick_type,
  output logic [`POS_LEN-1:0]   cur_pos,
  output logic [`DIR_LEN-1:0]   dir,
  output logic [`BRICK_LEN-1:0] brick_type,
  output logic                  lock_req,
  output logic                  game_over,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int XW = `POS_LEN / 2;
  localparam int SW = $clog2(DROP_MAX + 1);
  localparam logic [`POS_LEN-1:0] SPAWN_POS = `MAKE_POS(SPAWN_X, SPAWN_Y);

  // Requester bit positions; lower index wins arbitration.
  localparam int OP_SPAWN = 0;
  localparam int OP_DROP  = 1;
  localparam int OP_GRAV  = 2;
  localparam int OP_DOWN  = 3;
  localparam int OP_LEFT  = 4;
  localparam int OP_RIGHT = 5;
  localparam int OP_ROT   = 6;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CHECK     = 2'd1,
    S_DROP_STEP = 2'd2,
    S_LOCK      = 2'd3
  } state_t;

  state_t                state;
  logic [6:0]            pend_q;
  logic [6:0]            pend_eff;
  logic [6:0]            grant;
  logic [6:0]            op_q;
  logic [`BRICK_LEN-1:0] spawn_type_q;
  logic [SW-1:0]         step_cnt;
  logic [1:0]            kick;
  logic [XW-1:0]         cur_x;
  logic [XW-1:0]         cur_y;
  logic [XW-1:0]         x_inc;
  logic [XW-1:0]         x_dec;
  logic [XW-1:0]         y_dec;

  assign cur_x = cur_pos[`POS_LEN-1:XW];
  assign cur_y = cur_pos[XW-1:0];
  assign x_inc = cur_x + XW'(1);
  assign x_dec = cur_x - XW'(1);
  assign y_dec = cur_y - XW'(1);

  assign pend_eff  = pend_q | {req_rot, req_right, req_left, req_down, req_grav, req_drop, spawn_req};
  assign grant     = pend_eff & (~pend_eff + 7'd1);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // lock_req rises on entry to LOCK and stays high until a cycle with lock_ack high;
  // that cycle completes the handshake and lock_req drops on the same edge.
  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      state          <= S_IDLE;
      cur_pos        <= SPAWN_POS;
      try_pos        <= SPAWN_POS;
      dir            <= '0;
      try_dir        <= '0;
      brick_type     <= `BRICK_I;
      try_brick_type <= `BRICK_I;
      spawn_type_q   <= `BRICK_I;
      pend_q         <= '0;
      op_q           <= '0;
      step_cnt       <= '0;
      kick           <= '0;
      lock_req       <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      if (spawn_req) spawn_type_q <= spawn_type;
      pend_q <= pend_eff;
      case (state)
        S_IDLE: begin
          if (!game_over && grant != 7'd0) begin
            op_q           <= grant;
            kick           <= '0;
            step_cnt       <= SW'(1);
            state          <= S_CHECK;
            pend_q         <= grant[OP_SPAWN] ? 7'd0 : (pend_eff & ~grant);
            try_pos        <= cur_pos;
            try_dir        <= dir;
            try_brick_type <= brick_type;
            if (grant[OP_SPAWN]) begin
              try_pos        <= SPAWN_POS;
              try_dir        <= '0;
              try_brick_type <= spawn_req ? spawn_type : spawn_type_q;
            end else if (grant[OP_DROP] || grant[OP_GRAV] || grant[OP_DOWN]) begin
              try_pos <= {cur_x, y_dec};
            end else if (grant[OP_LEFT]) begin
              try_pos <= {x_dec, cur_y};
            end else if (grant[OP_RIGHT]) begin
              try_pos <= {x_inc, cur_y};
            end else begin
              try_dir <= dir + 1'b1;
            end
          end
        end
        S_CHECK: begin
          // A spawn is displayed even when it collides; game_over records the clash.
          if (!is_collided || op_q[OP_SPAWN]) begin
            cur_pos    <= try_pos;
            dir        <= try_dir;
            brick_type <= try_brick_type;
          end
          if (op_q[OP_SPAWN]) begin
            if (is_collided) game_over <= 1'b1;
            state <= S_IDLE;
          end else if (!is_collided) begin
            state <= op_q[OP_DROP] ? S_DROP_STEP : S_IDLE;
          end else if (op_q[OP_GRAV] || op_q[OP_DROP]) begin
            state    <= S_LOCK;
            lock_req <= 1'b1;
          end
`ifdef WALL_KICK_EN
          else if (op_q[OP_ROT] && kick != 2'd2) begin
            kick    <= kick + 2'd1;
            try_pos <= {(kick == 2'd0) ? x_inc : x_dec, cur_y};
          end
`endif
          else begin
            state <= S_IDLE;
          end
        end
        S_DROP_STEP: begin
          if (step_cnt >= SW'(DROP_MAX)) begin
            state    <= S_LOCK;
            lock_req <= 1'b1;
          end else begin
            try_pos  <= {cur_x, y_dec};
            step_cnt <= step_cnt + SW'(1);
            state    <= S_CHECK;
          end
        end
        S_LOCK: begin
          if (lock_ack) begin
            lock_req <= 1'b0;
            pend_q   <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: table vectors, hand-written corner sequences and randomized
// single requests checked against a board-level model of the brick's movement rules.
module tb_move_scheduler;
  localparam int W = 12;
  localparam int H = 20;
  localparam int DROP_MAX = 20;
  localparam logic [6:0] M_SPAWN = 7'b0000001;
  localparam logic [6:0] M_DROP  = 7'b0000010;
  localparam logic [6:0] M_GRAV  = 7'b0000100;
  localparam logic [6:0] M_DOWN  = 7'b0001000;
  localparam logic [6:0] M_LEFT  = 7'b0010000;
  localparam logic [6:0] M_RIGHT = 7'b0100000;
  localparam logic [6:0] M_ROT   = 7'b1000000;

  logic main_clk = 1'b0;
  logic rst_1plus;
  logic req_left, req_right, req_down, req_rot, req_grav, req_drop, spawn_req;
  logic [2:0] spawn_type;
  logic is_collided, lock_ack;
  logic [9:0] try_pos, cur_pos;
  logic [1:0] try_dir, dir;
  logic [2:0] try_brick_type, brick_type;
  logic lock_req, game_over, busy;
  logic [1:0] state_dbg;

  logic [H*W-1:0] board;
  int checks = 0;
  int errors = 0;

  logic [4:0] mx, my;
  logic [1:0] md;
  logic [2:0] mt;
  bit mgo, mlock;

  typedef struct {
    logic [6:0] req;
    int ex;
    int ey;
    int ed;
  } vec_t;
  vec_t tbl[10];

  move_scheduler dut (
    .main_clk(main_clk), .rst_1plus(rst_1plus),
    .req_left(req_left), .req_right(req_right), .req_down(req_down), .req_rot(req_rot),
    .req_grav(req_grav), .req_drop(req_drop), .spawn_req(spawn_req), .spawn_type(spawn_type),
    .is_collided(is_collided), .lock_ack(lock_ack),
    .try_pos(try_pos), .try_dir(try_dir), .try_brick_type(try_brick_type),
    .cur_pos(cur_pos), .dir(dir), .brick_type(brick_type),
    .lock_req(lock_req), .game_over(game_over), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 main_clk = ~main_clk;

  function automatic bit cell_bad(logic [H*W-1:0] b, logic [4:0] x, logic [4:0] y);
    if (x >= 5'(W) || y >= 5'(H)) return 1'b1;
    return b[int'(y) * W + int'(x)];
  endfunction

  // Brick is two cells: its anchor plus one neighbour chosen by direction.
  function automatic bit collides(logic [H*W-1:0] b, logic [4:0] x, logic [4:0] y, logic [1:0] d);
    logic [4:0] x2, y2;
    x2 = x;
    y2 = y;
    case (d)
      2'd0: x2 = x + 5'd1;
      2'd1: y2 = y + 5'd1;
      2'd2: x2 = x - 5'd1;
      default: y2 = y - 5'd1;
    endcase
    return cell_bad(b, x, y) || cell_bad(b, x2, y2);
  endfunction

  always_comb is_collided = collides(board, try_pos[9:5], try_pos[4:0], try_dir);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [6:0] m);
    spawn_req = m[0]; req_drop = m[1]; req_grav = m[2]; req_down = m[3];
    req_left = m[4]; req_right = m[5]; req_rot = m[6];
    @(negedge main_clk);
    {spawn_req, req_drop, req_grav, req_down, req_left, req_right, req_rot} = '0;
  endtask

  task automatic settle(input string name);
    int idle_run = 0;
    for (int i = 0; i < 300; i++) begin
      if (lock_req) return;
      idle_run = busy ? 0 : idle_run + 1;
      if (idle_run >= 3) return;
      @(negedge main_clk);
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic ack();
    lock_ack = 1'b1;
    @(negedge main_clk);
    lock_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_1plus = 1'b1;
    {spawn_req, req_drop, req_grav, req_down, req_left, req_right, req_rot} = '0;
    spawn_type = 3'd1;
    lock_ack = 1'b0;
    board = '0;
    repeat (2) @(negedge main_clk);
    rst_1plus = 1'b0;
    @(negedge main_clk);
    mx = 5'd6; my = 5'd18; md = 2'd0; mt = 3'd1; mgo = 1'b0; mlock = 1'b0;
  endtask

  task automatic chk_cur(input string name, input int x, input int y, input int d);
    chk({name, "_x"}, 32'(cur_pos[9:5]), x);
    chk({name, "_y"}, 32'(cur_pos[4:0]), y);
    chk({name, "_dir"}, 32'(dir), d);
  endtask

  // Reference model: each request moves the brick by the game rules on the board.
  task automatic model_apply(input logic [6:0] m);
    logic [1:0] nd;
    int steps;
    if (mgo) return;
    if (m == M_LEFT && !collides(board, mx - 5'd1, my, md)) mx = mx - 5'd1;
    if (m == M_RIGHT && !collides(board, mx + 5'd1, my, md)) mx = mx + 5'd1;
    if (m == M_DOWN && !collides(board, mx, my - 5'd1, md)) my = my - 5'd1;
    if (m == M_GRAV) begin
      if (collides(board, mx, my - 5'd1, md)) mlock = 1'b1;
      else my = my - 5'd1;
    end
    if (m == M_DROP) begin
      steps = 0;
      while (!mlock) begin
        if (steps == DROP_MAX || collides(board, mx, my - 5'd1, md)) mlock = 1'b1;
        else begin
          my = my - 5'd1;
          steps++;
        end
      end
    end
    if (m == M_ROT) begin
      nd = md + 2'd1;
      if (!collides(board, mx, my, nd)) md = nd;
`ifdef WALL_KICK_EN
      else if (!collides(board, mx + 5'd1, my, nd)) begin md = nd; mx = mx + 5'd1; end
      else if (!collides(board, mx - 5'd1, my, nd)) begin md = nd; mx = mx - 5'd1; end
`endif
    end
  endtask

  task automatic absorb();
    logic [4:0] x2, y2;
    x2 = mx; y2 = my;
    case (md)
      2'd0: x2 = mx + 5'd1;
      2'd1: y2 = my + 5'd1;
      2'd2: x2 = mx - 5'd1;
      default: y2 = my - 5'd1;
    endcase
    if (!cell_bad(board, mx, my)) board[int'(my) * W + int'(mx)] = 1'b1;
    if (!cell_bad(board, x2, y2)) board[int'(y2) * W + int'(x2)] = 1'b1;
  endtask

  initial begin
    logic [6:0] opts[6];
    logic [6:0] m;
    logic [2:0] t;
    opts = '{M_DROP, M_GRAV, M_DOWN, M_LEFT, M_RIGHT, M_ROT};

    tbl[0] = '{M_RIGHT, 7, 18, 0};
    tbl[1] = '{M_LEFT,  6, 18, 0};
    tbl[2] = '{M_DOWN,  6, 17, 0};
    tbl[3] = '{M_ROT,   6, 17, 1};
    tbl[4] = '{M_GRAV,  6, 16, 1};
    tbl[5] = '{M_ROT,   6, 16, 2};
    tbl[6] = '{M_ROT,   6, 16, 3};
    tbl[7] = '{M_ROT,   6, 16, 0};
    tbl[8] = '{M_RIGHT, 7, 16, 0};
    tbl[9] = '{M_DOWN,  7, 15, 0};

    // Reset values
    do_reset();
    chk_cur("reset_cur", 6, 18, 0);
    chk("reset_try_pos", 32'(try_pos), 32'({5'd6, 5'd18}));
    chk("reset_try_dir", 32'(try_dir), 0);
    chk("reset_type", 32'(brick_type), 1);
    chk("reset_try_type", 32'(try_brick_type), 1);
    chk("reset_lock", 32'(lock_req), 0);
    chk("reset_go", 32'(game_over), 0);
    chk("reset_busy", 32'(busy), 0);

    // Two-cycle latency of a single move
    pulse(M_RIGHT);
    chk_cur("lat_edge1", 6, 18, 0);
    chk("lat_busy1", 32'(busy), 1);
    @(negedge main_clk);
    chk_cur("lat_edge2", 7, 18, 0);
    chk("lat_busy2", 32'(busy), 0);

    // Table of single requests on an empty board
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pulse(tbl[i].req);
      settle("tbl");
      chk_cur($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ed);
      chk($sformatf("tbl%0d_lock", i), 32'(lock_req), 0);
    end

    // Simultaneous left + gravity: gravity granted first
    do_reset();
    pulse(M_LEFT | M_GRAV);
    chk_cur("sim_e1", 6, 18, 0);
    @(negedge main_clk);
    chk_cur("sim_e2", 6, 17, 0);
    @(negedge main_clk);
    chk_cur("sim_e3", 6, 17, 0);
    @(negedge main_clk);
    chk_cur("sim_e4", 5, 17, 0);
    chk("sim_busy", 32'(busy), 0);

    // Left against the wall at x=0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulse(M_LEFT);
      settle("wall_walk");
    end
    chk_cur("wall_at0", 0, 18, 0);
    pulse(M_LEFT);
    settle("wall_blk");
    chk_cur("wall_blocked", 0, 18, 0);
    chk("wall_lock", 32'(lock_req), 0);

    // Hard drop to the floor, lock handshake
    do_reset();
    pulse(M_DROP);
    for (int i = 0; i < 100 && !lock_req; i++) @(negedge main_clk);
    chk("drop_lock", 32'(lock_req), 1);
    chk_cur("drop_floor", 6, 0, 0);
    repeat (5) @(negedge main_clk);
    chk("drop_lock_held", 32'(lock_req), 1);
    ack();
    chk("drop_lock_rel", 32'(lock_req), 0);
    chk("drop_busy_rel", 32'(busy), 0);

    // Spawn onto an occupied site
    do_reset();
    board[18 * W + 6] = 1'b1;
    spawn_type = 3'd3;
    pulse(M_SPAWN);
    @(negedge main_clk);
    chk("go_set", 32'(game_over), 1);
    chk("go_type", 32'(brick_type), 3);
    chk_cur("go_cur", 6, 18, 0);
    pulse(M_RIGHT);
    settle("go_r");
    pulse(M_DOWN);
    settle("go_d");
    chk_cur("go_frozen", 6, 18, 0);
    chk("go_busy", 32'(busy), 0);

    // Rotation blocked in place, free one column right
    do_reset();
    board[19 * W + 6] = 1'b1;
    pulse(M_ROT);
    settle("kick");
`ifdef WALL_KICK_EN
    chk_cur("kick", 7, 18, 1);
`else
    chk_cur("kick", 6, 18, 0);
`endif

    // Randomized single requests against the reference model
    do_reset();
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < W; x++)
        if ($urandom_range(0, 99) < 20) board[y * W + x] = 1'b1;
    for (int it = 0; it < 200; it++) begin
      m = opts[$urandom_range(0, 5)];
      pulse(m);
      settle("rnd");
      model_apply(m);
      chk_cur($sformatf("rnd%0d", it), int'(mx), int'(my), int'(md));
      chk($sformatf("rnd%0d_lock", it), 32'(lock_req), 32'(mlock));
      if (mlock) begin
        absorb();
        ack();
        mlock = 1'b0;
        t = 3'($urandom_range(1, 7));
        spawn_type = t;
        pulse(M_SPAWN);
        settle("rnd_spawn");
        if (!mgo) begin
          mx = 5'd6; my = 5'd18; md = 2'd0; mt = t;
          if (collides(board, mx, my, md)) mgo = 1'b1;
        end
        chk_cur($sformatf("rnd%0d_spawn", it), int'(mx), int'(my), int'(md));
        chk($sformatf("rnd%0d_type", it), 32'(brick_type), 32'(mt));
        chk($sformatf("rnd%0d_go", it), 32'(game_over), 32'(mgo));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
